// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: condition-code constants and branch_resolver state encoding shared across the resolver slice
package branch_resolver_pkg;
  localparam logic [2:0] CC_Z  = 3'd0;
  localparam logic [2:0] CC_NZ = 3'd1;
  localparam logic [2:0] CC_C  = 3'd2;
  localparam logic [2:0] CC_NC = 3'd3;
  localparam logic [2:0] CC_P  = 3'd4;
  localparam logic [2:0] CC_N  = 3'd5;
  localparam logic [2:0] CC_PO = 3'd6;
  localparam logic [2:0] CC_PE = 3'd7;
  typedef enum logic [1:0] {
    BR_IDLE  = 2'd0,
    BR_WAIT  = 2'd1,
    BR_DONE  = 2'd2,
    BR_FLUSH = 2'd3
  } br_state_t;
endpackage

// File: rtl/branch_resolver_flush_counter.sv
// flush_counter: 4-bit loadable down-counter (clk, rst, load/load_val, dec) reporting zero; holds at 0
module flush_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [3:0] count;
  assign zero = count == 4'd0;
  always_ff @(posedge clk) begin
    if (rst) count <= 4'd0;
    else if (load) count <= load_val;
    else if (dec && !zero) count <= count - 4'd1;
  end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: resolves jumps from decode (br_*), waits out flag hazards (fl_wr_inflight, FL via OC_fl), issues registered ack/redirect/flush
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic              br_uncond,
  input  logic [2:0]        br_oc_fl,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              fl_wr_inflight,
  input  logic              FL,
  output logic [2:0]        OC_fl,
  output logic              br_ack,
  output logic              taken,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush
);
  br_state_t state, state_n;
  logic resolve, enter_flush, cnt_zero;
  assign OC_fl = br_oc_fl;
  assign resolve = br_valid & (br_uncond | ~fl_wr_inflight);
  always_comb begin
    state_n = state;
    state_n = (state == BR_DONE)  ? BR_IDLE :
              (state == BR_FLUSH) ? (cnt_zero ? BR_IDLE : BR_FLUSH) :
              resolve             ? ((br_uncond | FL) ? BR_FLUSH : BR_DONE) :
              br_valid            ? BR_WAIT : BR_IDLE;
  end
  assign enter_flush = (state_n == BR_FLUSH) && (state != BR_FLUSH);
  flush_counter u_flush_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (enter_flush),
    .load_val (4'(FLUSH_DEPTH - 1)),
    .dec      (state == BR_FLUSH),
    .zero     (cnt_zero)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BR_IDLE;
      br_ack      <= 1'b0;
      taken       <= 1'b0;
      redirect    <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state    <= state_n;
      br_ack   <= enter_flush | (state_n == BR_DONE);
      taken    <= enter_flush;
      redirect <= enter_flush;
      flush    <= state_n == BR_FLUSH;
      if (enter_flush) redirect_pc <= br_target;
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed self-checking bench for branch_resolver (FLUSH_DEPTH 2 and 4 instances)
module tb_branch_resolver;
  logic       clk = 1'b0;
  logic       rst, rst4;
  logic       br_valid, br_valid4, br_uncond, fl_wr_inflight;
  logic [2:0] br_oc_fl;
  logic [7:0] br_target;
  logic       FL, FL4;
  logic       z, c;
  logic [2:0] oc, oc4;
  logic       ack, tkn, rdr, fl;
  logic       ack4, tkn4, rdr4, fl4;
  logic [7:0] pc, pc4;
  int         n_checks = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  always_comb begin
    FL = 1'b0;
    case (oc)
      3'd0: FL = z;
      3'd1: FL = ~z;
      3'd2: FL = c;
      3'd3: FL = ~c;
      default: FL = 1'b0;
    endcase
  end
  always_comb begin
    FL4 = 1'b0;
    case (oc4)
      3'd0: FL4 = z;
      3'd1: FL4 = ~z;
      3'd2: FL4 = c;
      3'd3: FL4 = ~c;
      default: FL4 = 1'b0;
    endcase
  end
  branch_resolver #(.ADDR_W(8), .FLUSH_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_uncond(br_uncond),
    .br_oc_fl(br_oc_fl), .br_target(br_target), .fl_wr_inflight(fl_wr_inflight),
    .FL(FL), .OC_fl(oc), .br_ack(ack), .taken(tkn), .redirect(rdr),
    .redirect_pc(pc), .flush(fl)
  );
  branch_resolver #(.ADDR_W(8), .FLUSH_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst4), .br_valid(br_valid4), .br_uncond(br_uncond),
    .br_oc_fl(br_oc_fl), .br_target(br_target), .fl_wr_inflight(fl_wr_inflight),
    .FL(FL4), .OC_fl(oc4), .br_ack(ack4), .taken(tkn4), .redirect(rdr4),
    .redirect_pc(pc4), .flush(fl4)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic outs(input string tag, input logic a, input logic t, input logic r, input logic f, input logic [7:0] p);
    check({tag, ".ack"}, 32'(ack), 32'(a));
    check({tag, ".taken"}, 32'(tkn), 32'(t));
    check({tag, ".redirect"}, 32'(rdr), 32'(r));
    check({tag, ".flush"}, 32'(fl), 32'(f));
    check({tag, ".pc"}, 32'(pc), 32'(p));
  endtask
  task automatic outs4(input string tag, input logic a, input logic t, input logic r, input logic f, input logic [7:0] p);
    check({tag, ".ack4"}, 32'(ack4), 32'(a));
    check({tag, ".taken4"}, 32'(tkn4), 32'(t));
    check({tag, ".redirect4"}, 32'(rdr4), 32'(r));
    check({tag, ".flush4"}, 32'(fl4), 32'(f));
    check({tag, ".pc4"}, 32'(pc4), 32'(p));
  endtask
  initial begin
    rst = 1'b1; rst4 = 1'b1;
    br_valid = 1'b0; br_valid4 = 1'b0; br_uncond = 1'b0; fl_wr_inflight = 1'b0;
    br_oc_fl = 3'd0; br_target = 8'h00; z = 1'b0; c = 1'b0;
    tick(); tick();
    rst = 1'b0; rst4 = 1'b0;
    outs("reset", 0, 0, 0, 0, 8'h00);
    outs4("reset", 0, 0, 0, 0, 8'h00);
    tick();
    outs("idle", 0, 0, 0, 0, 8'h00);
    z = 1'b1; br_oc_fl = 3'd0; br_target = 8'h3C; br_valid = 1'b1;
    #1 check("oc_pass_z", 32'(oc), 32'd0);
    tick();
    outs("z_taken", 1, 1, 1, 1, 8'h3C);
    br_target = 8'h55; br_uncond = 1'b1;
    tick();
    outs("flush2", 0, 0, 0, 1, 8'h3C);
    tick();
    outs("flush_end_ignored", 0, 0, 0, 0, 8'h3C);
    tick();
    outs("reaccept_uncond", 1, 1, 1, 1, 8'h55);
    br_valid = 1'b0; br_uncond = 1'b0;
    tick(); tick();
    outs("quiet1", 0, 0, 0, 0, 8'h55);
    c = 1'b0; br_oc_fl = 3'd2; br_valid = 1'b1;
    #1 check("oc_pass_c", 32'(oc), 32'd2);
    tick();
    outs("c_not_taken", 1, 0, 0, 0, 8'h55);
    tick();
    outs("done_no_reack", 0, 0, 0, 0, 8'h55);
    br_valid = 1'b0;
    tick();
    outs("quiet2", 0, 0, 0, 0, 8'h55);
    z = 1'b1; br_oc_fl = 3'd1; br_target = 8'hA7; fl_wr_inflight = 1'b1; br_valid = 1'b1;
    tick();
    outs("haz_wait1", 0, 0, 0, 0, 8'h55);
    tick();
    outs("haz_wait2", 0, 0, 0, 0, 8'h55);
    tick();
    outs("haz_wait3", 0, 0, 0, 0, 8'h55);
    z = 1'b0; fl_wr_inflight = 1'b0;
    tick();
    outs("haz_nz_taken", 1, 1, 1, 1, 8'hA7);
    br_valid = 1'b0;
    tick(); tick();
    outs("quiet3", 0, 0, 0, 0, 8'hA7);
    z = 1'b1; br_oc_fl = 3'd1; br_uncond = 1'b1; fl_wr_inflight = 1'b1; br_target = 8'h9A; br_valid = 1'b1;
    tick();
    outs("uncond_haz", 1, 1, 1, 1, 8'h9A);
    br_valid = 1'b0; br_uncond = 1'b0; fl_wr_inflight = 1'b0;
    tick(); tick();
    outs("quiet4", 0, 0, 0, 0, 8'h9A);
    z = 1'b0; br_oc_fl = 3'd0; br_target = 8'h11; fl_wr_inflight = 1'b1; br_valid = 1'b1;
    tick();
    outs("drop_wait", 0, 0, 0, 0, 8'h9A);
    br_valid = 1'b0;
    tick();
    outs("drop_idle", 0, 0, 0, 0, 8'h9A);
    fl_wr_inflight = 1'b0; z = 1'b1;
    tick();
    outs("drop_no_ack", 0, 0, 0, 0, 8'h9A);
    br_uncond = 1'b1; br_target = 8'h77; br_valid4 = 1'b1;
    tick();
    outs4("d4_taken", 1, 1, 1, 1, 8'h77);
    br_valid4 = 1'b0; br_uncond = 1'b0;
    tick();
    outs4("d4_flush2", 0, 0, 0, 1, 8'h77);
    rst4 = 1'b1;
    tick();
    outs4("d4_reset", 0, 0, 0, 0, 8'h00);
    rst4 = 1'b0;
    tick();
    outs4("d4_idle", 0, 0, 0, 0, 8'h00);
    z = 1'b0; br_oc_fl = 3'd0; br_valid4 = 1'b1;
    tick();
    outs4("d4_not_taken", 1, 0, 0, 0, 8'h00);
    br_valid4 = 1'b0;
    tick();
    outs4("d4_done", 0, 0, 0, 0, 8'h00);
    z = 1'b1; br_target = 8'hC3; br_valid4 = 1'b1;
    tick();
    outs4("d4_z_taken", 1, 1, 1, 1, 8'hC3);
    br_valid4 = 1'b0;
    tick(); tick(); tick();
    outs4("d4_flush4", 0, 0, 0, 1, 8'hC3);
    tick();
    outs4("d4_flush_end", 0, 0, 0, 0, 8'hC3);
    outs("dut_untouched", 0, 0, 0, 0, 8'h9A);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
